imem_loader: RTL



---
 rtl/imem_loader_if.sv | 51 +++++
 rtl/imem_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Bundles the control, byte-stream and memory-write signals of the
//   instruction-memory loader.
//
//   Parameters
//     ADDR_W     width of mem_addr (memory depth is 2**ADDR_W)
//
//   Signals
//     start      single-cycle load request
//     num_words  words to load, captured with start (1..2**ADDR_W)
//     rx_data    stream byte
//     rx_valid   rx_data is valid
//     rx_ready   loader accepts a byte this cycle
//     mem_we     instruction memory write strobe
//     mem_addr   write address
//     mem_wdata  write data
//     busy       load in progress
//     done       one-cycle pulse at the end of a load
//     err        checksum mismatch flag
//
//   Modports
//     master     host side: drives start/num_words and the byte stream,
//                observes everything else
//     slave      loader side
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, num_words, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );

  modport slave (
    input  start, num_words, rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Fills the instruction memory at run time from a byte stream. Bytes arrive
//   over a valid/ready handshake, are packed four at a time (most significant
//   byte first) into a 32-bit word, and each word is written at sequential
//   addresses starting from 0.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    imem_loader_if.slave (start, num_words, rx_data, rx_valid,
//            rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err)
//
//   Build option
//     IMEM_LOADER_CKSUM_EN  when defined, a trailing byte after the last word
//                           is compared with the XOR of all data bytes and err
//                           reports a mismatch. When undefined, err is tied 0.
//
//   All outputs are registered.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CKSUM,  // waiting for the trailing checksum byte
`else
    S_FLUSH,  // cycle carrying the final mem_we
`endif
    S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      byte_cnt;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] n_words;
  // Only the three earlier bytes need holding; the fourth comes straight
  // from rx_data in the cycle it is accepted.
  logic [23:0]     shreg;

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]      cksum;
  logic            err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  logic start_ok;
  logic last_word;

  assign start_ok  = bus.start && (bus.num_words != '0) && (bus.num_words <= DEPTH_W);
  assign last_word = (word_cnt == n_words - 1'b1);

  // NOTE: every register here uses <= so all state updates see the values
  // from before the edge; mixing in = would make results order-dependent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      byte_cnt      <= '0;
      word_cnt      <= '0;
      n_words       <= '0;
      shreg         <= '0;
      bus.rx_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      bus.mem_we <= 1'b0;
      bus.done   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            n_words      <= bus.num_words;
            byte_cnt     <= '0;
            word_cnt     <= '0;
            bus.rx_ready <= 1'b1;
            bus.busy     <= 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum        <= '0;
            err_q        <= 1'b0;
`endif
            state        <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (bus.rx_valid) begin
            shreg    <= {shreg[15:0], bus.rx_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum    <= cksum ^ bus.rx_data;
`endif
            if (byte_cnt == 2'd3) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= word_cnt[ADDR_W-1:0];
              bus.mem_wdata <= {shreg, bus.rx_data};
              word_cnt      <= word_cnt + 1'b1;
              if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
                // rx_ready stays high: the checksum byte may follow at once.
                state        <= S_CKSUM;
`else
                bus.rx_ready <= 1'b0;
                state        <= S_FLUSH;
`endif
              end
            end
          end
        end

`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM: begin
          if (bus.rx_valid) begin
            err_q        <= (bus.rx_data != cksum);
            bus.rx_ready <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= S_DONE;
          end
        end
`else
        S_FLUSH: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= S_DONE;
        end
`endif

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
